// File: rtl/channel_readout_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// channel_readout_scheduler_pkg
// Shared definitions for the channel readout scheduler: FSM state encoding,
// header marker layout and the timeout counter width.
// Also supplies a fallback for the __TX_WIDTH define normally provided by
// conf_regs_defines.v, so the block elaborates stand-alone.
// -----------------------------------------------------------------------------
`ifndef __TX_WIDTH
`define __TX_WIDTH 8
`endif

package channel_readout_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RQST = 3'd1,
        ST_HDR  = 3'd2,
        ST_XFER = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Width of the per-channel response timeout counter.
    localparam int TMO_CNT_W = 16;

    // Header word carries the channel number (1 = CH1, 2 = CH2) in the low bits.
    localparam int HDR_ID_W = 2;

    function automatic logic [HDR_ID_W-1:0] hdr_marker(input logic ch);
        return ch ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/channel_readout_scheduler.sv
// -----------------------------------------------------------------------------
// channel_readout_scheduler
// Sequences readout of the two channel blocks onto one shared Tx stream.
// On an accepted start it requests each enabled channel in turn (CH1 first),
// forwards that channel's data/rdy/eof and returns the Tx ack to it. tx_eof is
// raised only on the final word of the last enabled channel. A channel that
// completes no beat within TIMEOUT_CYCLES of entering transfer is abandoned
// and its sticky timeout_err bit is set.
//
// Optional feature: define CHANNEL_READOUT_SCHEDULER_HEADER_EN to insert a
// one-word header (channel number in bits [1:0]) ahead of each channel.
//
// Ports:
//   clk, rst (async, active-low)
//   start, ch_en[1:0]        readout request and enable mask
//   busy, done, timeout_err  status
//   rqst_data_ch1/ch2        one-cycle buffer request per channel
//   tx_data/rdy/eof_ch1/ch2  channel Tx inputs, tx_ack_ch1/ch2 acks back
//   tx_data, tx_rdy, tx_eof  shared Tx output, tx_ack from Tx protocol
// -----------------------------------------------------------------------------
module channel_readout_scheduler
    import channel_readout_scheduler_pkg::*;
#(
    parameter int TX_DATA_WIDTH  = `__TX_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [1:0]               ch_en,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               timeout_err,
    output logic                     rqst_data_ch1,
    output logic                     rqst_data_ch2,
    input  logic [TX_DATA_WIDTH-1:0] tx_data_ch1,
    input  logic [TX_DATA_WIDTH-1:0] tx_data_ch2,
    input  logic                     tx_rdy_ch1,
    input  logic                     tx_rdy_ch2,
    input  logic                     tx_eof_ch1,
    input  logic                     tx_eof_ch2,
    output logic                     tx_ack_ch1,
    output logic                     tx_ack_ch2,
    output logic [TX_DATA_WIDTH-1:0] tx_data,
    output logic                     tx_rdy,
    output logic                     tx_eof,
    input  logic                     tx_ack
);

    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                   state, state_nxt;
    logic                     cur_ch;
    logic [1:0]               en_q;
    logic [TMO_CNT_W-1:0]     tmo_cnt;
    logic                     beat_seen;

    logic [TX_DATA_WIDTH-1:0] sel_data;
    logic                     sel_rdy;
    logic                     sel_eof;
    logic                     last_ch;
    logic                     beat;
    logic                     expired;
    logic                     ch_adv;

    assign sel_data = cur_ch ? tx_data_ch2 : tx_data_ch1;
    assign sel_rdy  = cur_ch ? tx_rdy_ch2  : tx_rdy_ch1;
    assign sel_eof  = cur_ch ? tx_eof_ch2  : tx_eof_ch1;

    // CH2 is always last; CH1 is last only when CH2 is not enabled.
    assign last_ch  = cur_ch | ~en_q[1];
    assign beat     = (state == ST_XFER) & sel_rdy & tx_ack;
    // A beat landing on the final allowed cycle still counts as a response.
    assign expired  = (state == ST_XFER) & ~beat_seen & ~beat & (tmo_cnt == TMO_LAST);
    assign ch_adv   = (beat & sel_eof) | expired;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (ch_en != 2'b00) ? ST_RQST : ST_DONE;
                end
            end
`ifdef CHANNEL_READOUT_SCHEDULER_HEADER_EN
            ST_RQST: state_nxt = ST_HDR;
            ST_HDR: begin
                if (tx_ack) begin
                    state_nxt = ST_XFER;
                end
            end
`else
            ST_RQST: state_nxt = ST_XFER;
`endif
            ST_XFER: begin
                if (ch_adv) begin
                    state_nxt = last_ch ? ST_DONE : ST_RQST;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Channel selection, enable mask, timeout tracking and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_ch      <= 1'b0;
            en_q        <= 2'b00;
            tmo_cnt     <= '0;
            beat_seen   <= 1'b0;
            timeout_err <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        en_q        <= ch_en;
                        timeout_err <= 2'b00;
                        cur_ch      <= ~ch_en[0];
                    end
                end
                ST_RQST: begin
                    tmo_cnt   <= '0;
                    beat_seen <= 1'b0;
                end
                ST_XFER: begin
                    if (beat) begin
                        beat_seen <= 1'b1;
                    end
                    if (!beat_seen) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                    if (expired) begin
                        timeout_err[cur_ch] <= 1'b1;
                    end
                    if (ch_adv && !last_ch) begin
                        cur_ch <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy          = (state != ST_IDLE);
        done          = (state == ST_DONE);
        rqst_data_ch1 = (state == ST_RQST) & ~cur_ch;
        rqst_data_ch2 = (state == ST_RQST) &  cur_ch;
        tx_data       = '0;
        tx_rdy        = 1'b0;
        tx_eof        = 1'b0;
        tx_ack_ch1    = 1'b0;
        tx_ack_ch2    = 1'b0;
        case (state)
            ST_XFER: begin
                tx_data    = sel_data;
                tx_rdy     = sel_rdy;
                tx_eof     = sel_eof & last_ch;
                tx_ack_ch1 = ~cur_ch & tx_ack;
                tx_ack_ch2 =  cur_ch & tx_ack;
            end
`ifdef CHANNEL_READOUT_SCHEDULER_HEADER_EN
            ST_HDR: begin
                tx_data = TX_DATA_WIDTH'(hdr_marker(cur_ch));
                tx_rdy  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
